ca_rule_ctrl: RTL and testbench
===============================

# ca_rule_ctrl

Frame-synchronous rule sequencer feeding the VGA elementary-CA renderer. It debounces the user buttons and selects the active Wolfram rule from an 8-entry table, by manual step, automatic cycling or a custom byte. It updates the rule only at frame boundaries, so a frame never tears. It also issues the per-frame seed request that tells the renderer to restart from a single-cell seed.

## Interface
- `DEBOUNCE_BITS`, default 16: debounce counter width; a button must be stable for 2^DEBOUNCE_BITS−1 cycles.
- `AUTO_FRAMES`, default 240: frames per rule in auto mode; must be ≥ 1.
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `frame_start` in 1: one-cycle pulse at pixel (0,0) from the timing generator.
- `btn_next` in 1: async button, step to the next rule.
- `btn_prev` in 1: async button, step to the previous rule.
- `btn_reseed` in 1: async button, reseed on the next frame.
- `sw_auto` in 1: async level, enables auto cycling.
- `sw_custom` in 1: async level, uses `custom_rule`.
- `custom_rule` in 8: async rule byte.
- `rule` out 8: active rule number.
- `rule_color` out 6: `rule[6:1]`, RGB222 colour for live cells.
- `rule_idx` out 3: table index.
- `mode` out 2: 0 MANUAL, 1 AUTO, 2 CUSTOM.
- `seed_req` out 1: current frame must be seeded.

## Operation
- Rule table, index 0..7: 30, 110, 22, 73, 90, 146, 105, 102.
- Synchronisers: every async input, including each `custom_rule` bit, passes through a 2-flop synchroniser.
- Debounce, per button:
  - Each button keeps a stable state and a counter.
  - Counter clears whenever the synchronised value equals the stable state.
  - Otherwise the counter increments. On reaching all-ones, the stable state flips and the counter clears.
  - A 0→1 stable transition produces a one-cycle press pulse.
- Pending flags `p_next`, `p_prev`, `p_reseed`:
  - Each is set by its press pulse.
  - All three are consumed and cleared at `frame_start`.
  - A press pulse coinciding with `frame_start` sets the flag after the clear, so it applies at the next frame.
  - Multiple presses within one frame collapse into one step.
- Mode FSM, evaluated only at `frame_start` from the synchronised switches:
  - `sw_custom`=1 → CUSTOM.
  - Else `sw_auto`=1 → AUTO.
  - Else → MANUAL.
  - Entering AUTO from another mode clears the frame counter.
- Index update at `frame_start`, using the next mode:
  - MANUAL or AUTO: `p_next` alone increments `rule_idx` mod 8; `p_prev` alone decrements it mod 8; both together leave it unchanged.
  - AUTO, no step flag, frame counter = AUTO_FRAMES−1: increment `rule_idx` mod 8 and clear the counter.
  - AUTO, otherwise: counter +1.
  - AUTO, any manual step: clears the counter.
  - CUSTOM: `rule_idx` and the counter are held; step flags are discarded.
- Rule output:
  - `rule` = table[`rule_idx`] in MANUAL and AUTO.
  - `rule` = `custom_rule` (synchronised) in CUSTOM, sampled at `frame_start` and held for the frame.
  - On leaving CUSTOM, `rule` returns to table[`rule_idx`] at that same `frame_start`.
- Seeding:
  - At `frame_start`: `seed_req` ← `p_reseed`.
  - A rule value change at that `frame_start` also forces `seed_req`=1.
  - Reset sets `p_reseed`=1, so the first frame after reset is seeded.

## Timing
- Reset values: `rule_idx`=0, `rule`=30, `rule_color`=6'h0F, `mode`=0, `seed_req`=0, counters 0, debounce stable states 0, `p_reseed`=1, other flags 0.
- Frame alignment: all outputs are registered and change only on the edge that samples `frame_start`=1; they are valid from the following cycle.
- Press latency: a clean button edge produces a press pulse 2 + (2^DEBOUNCE_BITS−1) + 1 cycles later.
- Glitch rejection: a glitch shorter than 2^DEBOUNCE_BITS−1 cycles produces no pulse.
- Reset mid-frame: state returns to reset values immediately; synchroniser flops are also reset to 0.
- Reset vs `frame_start`: reset has priority over a coincident `frame_start`.
- Missing frames: with no `frame_start`, outputs hold indefinitely.

## Test plan
- Reset, then pulse `frame_start` → `rule`=30, `rule_color`=0x0F, `seed_req`=1 for the first frame; at the second `frame_start`, `seed_req`=0.
- `DEBOUNCE_BITS`=2:
  - A 2-cycle `btn_next` glitch → no change.
  - A held `btn_next` → at the next `frame_start`, `rule_idx`=1, `rule`=110, `seed_req`=1.
  - `btn_prev` from index 0 → `rule_idx`=7, `rule`=102.
- Press `btn_next` and `btn_prev` in the same frame → `rule_idx` unchanged and `seed_req`=0. Separately, three `btn_next` presses in one frame → single step.
- `AUTO_FRAMES`=3, `sw_auto`=1 → `rule_idx` advances 0→1→2 every 3 `frame_start`s, with a wrap 7→0 at the end. A manual step restarts the 3-frame count.
- `sw_custom`=1, `custom_rule`=8'hB4 → at `frame_start`, `rule`=0xB4, `rule_color`=6'h1A, `mode`=2.
  - Changing `custom_rule` mid-frame leaves `rule` unchanged until the next `frame_start`.
  - Releasing `sw_custom` → `rule` returns to the table entry.
- Assert `rst_n`=0 in the cycle where `frame_start`=1 while in AUTO at index 5 → all outputs take their reset values; the next frame is seeded.

Source files
------------

// File: rtl/ca_rule_ctrl_if.sv
// Rule-controller bus: frame timing, user controls in; active rule and seeding status out.
// The timing generator / user-input side is the master, the controller is the slave.
interface ca_rule_ctrl_if;
  logic       frame_start;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_reseed;
  logic       sw_auto;
  logic       sw_custom;
  logic [7:0] custom_rule;
  logic [7:0] rule;
  logic [5:0] rule_color;
  logic [2:0] rule_idx;
  logic [1:0] mode;
  logic       seed_req;

  modport master (
    output frame_start, btn_next, btn_prev, btn_reseed, sw_auto, sw_custom, custom_rule,
    input  rule, rule_color, rule_idx, mode, seed_req
  );

  modport slave (
    input  frame_start, btn_next, btn_prev, btn_reseed, sw_auto, sw_custom, custom_rule,
    output rule, rule_color, rule_idx, mode, seed_req
  );
endinterface

// File: rtl/ca_rule_ctrl.sv
// Frame-synchronous Wolfram rule sequencer: debounced buttons, manual/auto/custom rule
// selection and per-frame seed requests, all applied only at frame_start.
module ca_rule_ctrl #(
  parameter int unsigned DEBOUNCE_BITS = 16,
  parameter int unsigned AUTO_FRAMES   = 240
) (
  input logic           clk,
  input logic           rst_n,
  ca_rule_ctrl_if.slave bus
);

  localparam int unsigned CntW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(AUTO_FRAMES - 1);
  localparam logic [DEBOUNCE_BITS-1:0] DbOne = DEBOUNCE_BITS'(1);

  typedef enum logic [1:0] {
    StManual = 2'd0,
    StAuto   = 2'd1,
    StCustom = 2'd2
  } mode_e;

  function automatic logic [7:0] rule_lut(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd0:    r = 8'd30;
      3'd1:    r = 8'd110;
      3'd2:    r = 8'd22;
      3'd3:    r = 8'd73;
      3'd4:    r = 8'd90;
      3'd5:    r = 8'd146;
      3'd6:    r = 8'd105;
      default: r = 8'd102;
    endcase
    return r;
  endfunction

  // Bit map: [0] next, [1] prev, [2] reseed, [3] sw_auto, [4] sw_custom, [12:5] custom_rule
  logic [12:0] async_in, sync1_q, sync2_q;
  assign async_in = {bus.custom_rule, bus.sw_custom, bus.sw_auto,
                     bus.btn_reseed, bus.btn_prev, bus.btn_next};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
    end
  end

  logic [2:0] btn_s;
  logic       sw_auto_s, sw_custom_s;
  logic [7:0] custom_s;
  assign btn_s       = sync2_q[2:0];
  assign sw_auto_s   = sync2_q[3];
  assign sw_custom_s = sync2_q[4];
  assign custom_s    = sync2_q[12:5];

  // Debounce: flip the stable state once the mismatch count would reach all-ones.
  logic [2:0]               stable_q, press_q;
  logic [DEBOUNCE_BITS-1:0] db_cnt_q [3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        press_q[i] <= 1'b0;
        if (btn_s[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (&(db_cnt_q[i] + DbOne)) begin
          stable_q[i] <= ~stable_q[i];
          db_cnt_q[i] <= '0;
          press_q[i]  <= ~stable_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbOne;
        end
      end
    end
  end

  // Pending flags {reseed, prev, next}
  logic [2:0]      pend_q, pend_d;
  mode_e           mode_q, mode_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] fcnt_q, fcnt_d;
  logic [7:0]      rule_q, rule_d;
  logic            seed_q, seed_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 3'b100;
      mode_q <= StManual;
      idx_q  <= '0;
      fcnt_q <= '0;
      rule_q <= 8'd30;
      seed_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mode_q <= mode_d;
      idx_q  <= idx_d;
      fcnt_q <= fcnt_d;
      rule_q <= rule_d;
      seed_q <= seed_d;
    end
  end

  always_comb begin
    pend_d = pend_q | press_q;
    mode_d = mode_q;
    idx_d  = idx_q;
    fcnt_d = fcnt_q;
    rule_d = rule_q;
    seed_d = seed_q;
    if (bus.frame_start) begin
      // Presses landing on frame_start survive the clear and apply next frame.
      pend_d = press_q;
      if (sw_custom_s)    mode_d = StCustom;
      else if (sw_auto_s) mode_d = StAuto;
      else                mode_d = StManual;

      if (mode_d == StCustom) begin
        rule_d = custom_s;
      end else begin
        if (pend_q[0] && !pend_q[1])      idx_d = idx_q + 3'd1;
        else if (pend_q[1] && !pend_q[0]) idx_d = idx_q - 3'd1;
        if (mode_d == StAuto) begin
          if (mode_q != StAuto || pend_q[0] || pend_q[1]) begin
            fcnt_d = '0;
          end else if (fcnt_q == CntLast) begin
            idx_d  = idx_q + 3'd1;
            fcnt_d = '0;
          end else begin
            fcnt_d = fcnt_q + CntW'(1);
          end
        end
        rule_d = rule_lut(idx_d);
      end
      seed_d = pend_q[2] || (rule_d != rule_q);
    end
  end

  assign bus.rule       = rule_q;
  assign bus.rule_color = rule_q[6:1];
  assign bus.rule_idx   = idx_q;
  assign bus.mode       = mode_q;
  assign bus.seed_req   = seed_q;

endmodule

// File: tb/tb_ca_rule_ctrl.sv
// Scoreboard bench for ca_rule_ctrl: stimulus queues hand-computed expectations, a monitor
// compares them at each frame_start (or explicit probe) edge.
module tb_ca_rule_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic probe = 1'b0;
  always #5 clk = ~clk;

  ca_rule_ctrl_if bus ();

  ca_rule_ctrl #(
    .DEBOUNCE_BITS(2),
    .AUTO_FRAMES  (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] rule;
    logic [5:0] color;
    logic [2:0] idx;
    logic [1:0] mode;
    logic       seed;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] tbl [8];

  // Monitor: every sampled frame_start (outside reset) or probe pops one expectation.
  initial begin
    forever begin
      @(posedge clk);
      if ((bus.frame_start && rst_n) || probe) begin
        #1;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL no_expectation: DUT presented output with empty scoreboard");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (bus.rule !== e.rule || bus.rule_color !== e.color || bus.rule_idx !== e.idx ||
              bus.mode !== e.mode || bus.seed_req !== e.seed) begin
            n_bad++;
            $display("FAIL %s: got rule=%0d color=%h idx=%0d mode=%0d seed=%0d, want rule=%0d color=%h idx=%0d mode=%0d seed=%0d",
                     e.name, bus.rule, bus.rule_color, bus.rule_idx, bus.mode, bus.seed_req,
                     e.rule, e.color, e.idx, e.mode, e.seed);
          end
        end
      end
    end
  end

  task automatic push(input string name, input logic [7:0] r, input logic [2:0] i,
                      input logic [1:0] m, input logic s);
    exp_t e;
    e.name = name; e.rule = r; e.color = r[6:1]; e.idx = i; e.mode = m; e.seed = s;
    sb_q.push_back(e);
  endtask

  task automatic frame(input string name, input logic [7:0] r, input logic [2:0] i,
                       input logic [1:0] m, input logic s);
    push(name, r, i, m, s);
    @(negedge clk) bus.frame_start = 1'b1;
    @(negedge clk) bus.frame_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic [7:0] r, input logic [2:0] i,
                           input logic [1:0] m, input logic s);
    push(name, r, i, m, s);
    @(negedge clk) probe = 1'b1;
    @(negedge clk) probe = 1'b0;
  endtask

  // Long enough clean press/release for DEBOUNCE_BITS=2.
  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: bus.btn_next = 1'b1;
      1: bus.btn_prev = 1'b1;
      default: bus.btn_reseed = 1'b1;
    endcase
    repeat (10) @(negedge clk);
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0; bus.btn_reseed = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = 8'd30;  tbl[1] = 8'd110; tbl[2] = 8'd22;  tbl[3] = 8'd73;
    tbl[4] = 8'd90;  tbl[5] = 8'd146; tbl[6] = 8'd105; tbl[7] = 8'd102;
    bus.frame_start = 1'b0; bus.btn_next = 1'b0; bus.btn_prev = 1'b0; bus.btn_reseed = 1'b0;
    bus.sw_auto = 1'b0; bus.sw_custom = 1'b0; bus.custom_rule = 8'h00;

    repeat (3) @(negedge clk);
    check_now("reset_state", 8'd30, 3'd0, 2'd0, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    frame("first_frame_seeded", 8'd30, 3'd0, 2'd0, 1'b1);
    frame("second_frame_unseeded", 8'd30, 3'd0, 2'd0, 1'b0);

    // Two-cycle glitch is shorter than the 3-cycle debounce window.
    @(negedge clk) bus.btn_next = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_next = 1'b0;
    repeat (10) @(negedge clk);
    frame("glitch_rejected", 8'd30, 3'd0, 2'd0, 1'b0);

    press(0);
    frame("next_step", 8'd110, 3'd1, 2'd0, 1'b1);
    press(1);
    frame("prev_step", 8'd30, 3'd0, 2'd0, 1'b1);
    press(1);
    frame("prev_wrap", 8'd102, 3'd7, 2'd0, 1'b1);
    press(0);
    press(1);
    frame("next_prev_cancel", 8'd102, 3'd7, 2'd0, 1'b0);
    press(0); press(0); press(0);
    frame("triple_next_single", 8'd30, 3'd0, 2'd0, 1'b1);
    press(2);
    frame("reseed_only", 8'd30, 3'd0, 2'd0, 1'b1);
    frame("reseed_consumed", 8'd30, 3'd0, 2'd0, 1'b0);

    // Auto mode, 3 frames per rule.
    bus.sw_auto = 1'b1;
    repeat (4) @(negedge clk);
    frame("auto_enter", 8'd30, 3'd0, 2'd1, 1'b0);
    frame("auto_c1", 8'd30, 3'd0, 2'd1, 1'b0);
    frame("auto_c2", 8'd30, 3'd0, 2'd1, 1'b0);
    frame("auto_adv1", 8'd110, 3'd1, 2'd1, 1'b1);
    frame("auto_c1b", 8'd110, 3'd1, 2'd1, 1'b0);
    press(0);
    frame("auto_manual_step", 8'd22, 3'd2, 2'd1, 1'b1);
    frame("auto_restart1", 8'd22, 3'd2, 2'd1, 1'b0);
    frame("auto_restart2", 8'd22, 3'd2, 2'd1, 1'b0);
    frame("auto_adv3", 8'd73, 3'd3, 2'd1, 1'b1);
    for (int n = 1; n <= 30; n++) begin
      logic [2:0] ei;
      ei = 3'((3 + n / 3) % 8);
      frame($sformatf("auto_run%0d", n), tbl[ei], ei, 2'd1, (n % 3) == 0);
    end

    // Reset coinciding with frame_start while in AUTO at index 5.
    @(negedge clk) begin rst_n = 1'b0; bus.frame_start = 1'b1; end
    @(negedge clk) bus.frame_start = 1'b0;
    check_now("reset_mid_auto", 8'd30, 3'd0, 2'd0, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    frame("post_reset_seeded", 8'd30, 3'd0, 2'd1, 1'b1);

    // Custom rule.
    bus.custom_rule = 8'hB4;
    bus.sw_custom = 1'b1;
    repeat (4) @(negedge clk);
    frame("custom_enter", 8'hB4, 3'd0, 2'd2, 1'b1);
    bus.custom_rule = 8'h55;
    repeat (4) @(negedge clk);
    check_now("custom_held_midframe", 8'hB4, 3'd0, 2'd2, 1'b1);
    frame("custom_update", 8'h55, 3'd0, 2'd2, 1'b1);
    press(0);
    frame("custom_step_discarded", 8'h55, 3'd0, 2'd2, 1'b0);
    bus.sw_custom = 1'b0;
    bus.sw_auto = 1'b0;
    repeat (4) @(negedge clk);
    frame("custom_leave", 8'd30, 3'd0, 2'd0, 1'b1);
    frame("manual_after_custom", 8'd30, 3'd0, 2'd0, 1'b0);

    // No frame_start: outputs hold.
    repeat (20) @(negedge clk);
    check_now("hold_no_frames", 8'd30, 3'd0, 2'd0, 1'b0);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
